ti_share_compressor: RTL and testbench

- Registered consumer for the eight refreshed 4-bit shares produced by the combinational TI nonlinear stage (outputs z000..z111 XOR r0..r6).
- Latches all eight shares in a register bank, then XOR-compresses them into two 4-bit shares for the next S-box stage.
- Compression happens strictly after the register boundary, so glitches cannot recombine shares across the nonlinear layer.
- Adds a two-deep valid/ready pipeline so the S-box datapath can stall without losing shares.

---
 rtl/ti_pkg.sv | 13 +
 rtl/ti_pipe_stage.sv | 46 ++++
 rtl/ti_share_compressor.sv | 98 +++++++++
 tb/tb_ti_share_compressor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ti_pkg.sv
// Shared constants for the threshold-implementation share datapath:
// default share width, share-group index ranges and the zeroisation value.
package ti_pkg;

  localparam int   W        = 4;
  localparam int   NSH      = 8;
  localparam int   GRP_A_LO = 0;
  localparam int   GRP_A_HI = 3;
  localparam int   GRP_B_LO = 4;
  localparam int   GRP_B_HI = 7;
  localparam logic RST_BIT  = 1'b0;

endpackage

// File: rtl/ti_pipe_stage.sv
// Generic valid/ready register slice with synchronous flush; data holds its
// value when the slot empties so an idle stage introduces no extra toggling.
module ti_pipe_stage
  import ti_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          clr,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  logic          vld_r;
  logic [DW-1:0] dat_r;
  logic          load_s;

  assign in_rdy  = !vld_r || out_rdy;
  assign load_s  = in_vld && in_rdy;
  assign out_vld = vld_r;
  assign out_dat = dat_r;

  // Slot register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_r <= 1'b0;
      dat_r <= {DW{RST_BIT}};
    end else if (clr) begin
      vld_r <= 1'b0;
      dat_r <= {DW{RST_BIT}};
    end else if (load_s) begin
      vld_r <= 1'b1;
      dat_r <= in_dat;
    end else if (out_rdy) begin
      vld_r <= 1'b0;
    end else begin
      vld_r <= vld_r;
    end
  end

endmodule

// File: rtl/ti_share_compressor.sv
// Registers the eight refreshed TI shares, then XOR-compresses each group of
// four into one share strictly behind the register boundary.
module ti_share_compressor
  import ti_pkg::*;
#(
  parameter int W = ti_pkg::W
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         clr,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [W-1:0] in5,
  input  logic [W-1:0] in6,
  input  logic [W-1:0] in7,
  input  logic         i_vld,
  output logic         i_rdy,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         o_vld,
  input  logic         o_rdy,
  output logic [1:0]   occ
);

  logic [NSH*W-1:0] sh_s;
  logic             s1_vld_s;
  logic             adv2_s;
  logic [W-1:0]     xa_s;
  logic [W-1:0]     xb_s;
  logic [2*W-1:0]   s2_dat_s;
  logic             acc_s;
  logic             con_s;
  logic [1:0]       occ_r;

  ti_pipe_stage #(.DW(NSH*W)) u_s1 (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (clr),
    .in_vld  (i_vld),
    .in_rdy  (i_rdy),
    .in_dat  ({in7, in6, in5, in4, in3, in2, in1, in0}),
    .out_vld (s1_vld_s),
    .out_rdy (adv2_s),
    .out_dat (sh_s)
  );

  // Group folds read only registered shares and never mix group A with B.
  always_comb begin
    xa_s = {W{RST_BIT}};
    xb_s = {W{RST_BIT}};
    for (int g = GRP_A_LO; g <= GRP_A_HI; g++) begin
      xa_s = xa_s ^ sh_s[g*W +: W];
    end
    for (int g = GRP_B_LO; g <= GRP_B_HI; g++) begin
      xb_s = xb_s ^ sh_s[g*W +: W];
    end
  end

  ti_pipe_stage #(.DW(2*W)) u_s2 (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (clr),
    .in_vld  (s1_vld_s),
    .in_rdy  (adv2_s),
    .in_dat  ({xb_s, xa_s}),
    .out_vld (o_vld),
    .out_rdy (o_rdy),
    .out_dat (s2_dat_s)
  );

  assign out_a = s2_dat_s[W-1:0];
  assign out_b = s2_dat_s[2*W-1:W];

  // A flushed accept is dropped, so it must not count toward occupancy.
  assign acc_s = i_vld && i_rdy;
  assign con_s = o_vld && o_rdy;

  // Occupancy tracks the valid flags edge-for-edge from a dedicated register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      occ_r <= 2'd0;
    end else if (clr) begin
      occ_r <= 2'd0;
    end else begin
      case ({acc_s, con_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign occ = occ_r;

endmodule

// File: tb/tb_ti_share_compressor.sv
// Scoreboard bench for ti_share_compressor: expected share pairs are queued on
// each accepted input and compared when the output handshake fires.
module tb_ti_share_compressor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] x;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] in0 = 4'd0, in1 = 4'd0, in2 = 4'd0, in3 = 4'd0;
  logic [W-1:0] in4 = 4'd0, in5 = 4'd0, in6 = 4'd0, in7 = 4'd0;
  logic         i_vld = 1'b0;
  logic         i_rdy;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         o_vld;
  logic         o_rdy = 1'b0;
  logic [1:0]   occ;

  int   n_pass = 0;
  int   n_chk = 0;
  int   n_out = 0;
  exp_t sbq[$];

  ti_share_compressor #(.W(W)) dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .clr   (clr),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .in4   (in4),
    .in5   (in5),
    .in6   (in6),
    .in7   (in7),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .out_a (out_a),
    .out_b (out_b),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .occ   (occ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t mdl();
    exp_t         e;
    logic [W-1:0] v[8];
    v = '{in0, in1, in2, in3, in4, in5, in6, in7};
    e.a = v[0] ^ v[1] ^ v[2] ^ v[3];
    e.b = v[4] ^ v[5] ^ v[6] ^ v[7];
    e.x = 4'd0;
    for (int i = 0; i < 8; i++) e.x = e.x ^ v[i];
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_vec(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
    in0 = a0; in1 = a1; in2 = a2; in3 = a3;
    in4 = a4; in5 = a5; in6 = a6; in7 = a7;
  endtask

  task automatic set_rand();
    set_vec(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    chk("drain", sbq.size(), 0);
  endtask

  // Scoreboard monitor: decisions mirror what the next rising edge will see.
  always @(negedge CLK) begin
    exp_t e;
    if (!RSTn || clr) begin
      sbq.delete();
    end else begin
      if (o_vld && o_rdy) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("sb_a", out_a, e.a);
          chk("sb_b", out_b, e.b);
          chk("sb_ab_xor", out_a ^ out_b, e.x);
          n_out++;
        end
      end
      if (i_vld && i_rdy) sbq.push_back(mdl());
    end
  end

  initial begin
    int n0;
    int cnt;
    int rdy_ok;
    logic [W-1:0] hold_a, hold_b;
    exp_t ea;

    // Reset state
    tick();
    tick();
    @(negedge CLK);
    chk("rst_occ", occ, 0);
    chk("rst_ovld", o_vld, 0);
    chk("rst_outa", out_a, 0);
    chk("rst_outb", out_b, 0);
    tick();
    RSTn = 1'b1;
    #1;
    chk("rst_irdy", i_rdy, 1);

    // Basic vector with fixed latency
    o_rdy = 1'b1;
    set_vec(4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9);
    i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
    @(negedge CLK);
    chk("basic_not_early", o_vld, 0);
    tick();
    @(negedge CLK);
    chk("basic_ovld", o_vld, 1);
    chk("basic_outa", out_a, 4'hF);
    chk("basic_outb", out_b, 4'h9);
    chk("basic_xor", out_a ^ out_b, 4'h6);
    tick();
    drain();

    // Back-to-back stream
    n0 = n_out;
    cnt = 0;
    rdy_ok = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        set_rand();
        i_vld = 1'b1;
      end else begin
        i_vld = 1'b0;
      end
      @(negedge CLK);
      if (i < 16 && i_rdy) rdy_ok++;
      if (i >= 2 && o_vld) cnt++;
      tick();
    end
    chk("stream_irdy", rdy_ok, 16);
    chk("stream_ovld_run", cnt, 16);
    drain();
    chk("stream_count", n_out - n0, 16);

    // Backpressure then simultaneous accept/transfer/consume
    n0 = n_out;
    o_rdy = 1'b0;
    set_rand();
    ea = mdl();
    i_vld = 1'b1;
    tick();
    set_rand();
    tick();
    set_rand();
    @(negedge CLK);
    chk("bp_occ", occ, 2);
    chk("bp_irdy", i_rdy, 0);
    chk("bp_ovld", o_vld, 1);
    chk("bp_outa", out_a, ea.a);
    hold_a = out_a;
    hold_b = out_b;
    tick();
    tick();
    @(negedge CLK);
    chk("bp_hold_a", out_a, hold_a);
    chk("bp_hold_b", out_b, hold_b);
    chk("bp_hold_occ", occ, 2);
    tick();
    o_rdy = 1'b1;
    #1;
    chk("sim_irdy", i_rdy, 1);
    tick();
    i_vld = 1'b0;
    @(negedge CLK);
    chk("sim_occ", occ, 2);
    drain();
    chk("bp_count", n_out - n0, 3);

    // Flush with both stages full and an input offered
    o_rdy = 1'b0;
    set_rand();
    i_vld = 1'b1;
    tick();
    set_rand();
    tick();
    set_rand();
    clr = 1'b1;
    @(negedge CLK);
    chk("clr_pre_occ", occ, 2);
    tick();
    clr = 1'b0;
    i_vld = 1'b0;
    @(negedge CLK);
    chk("clr_occ", occ, 0);
    chk("clr_ovld", o_vld, 0);
    chk("clr_outa", out_a, 0);
    chk("clr_outb", out_b, 0);
    o_rdy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge CLK);
      if (o_vld) cnt++;
    end
    chk("clr_no_ghost", cnt, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_rand();
      i_vld = 1'b1;
      tick();
    end
    #2;
    RSTn = 1'b0;
    i_vld = 1'b0;
    #1;
    chk("arst_occ", occ, 0);
    chk("arst_ovld", o_vld, 0);
    chk("arst_outa", out_a, 0);
    chk("arst_outb", out_b, 0);
    tick();
    #2;
    RSTn = 1'b1;
    tick();
    set_vec(4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA);
    i_vld = 1'b1;
    tick();
    i_vld = 1'b0;
    @(negedge CLK);
    chk("arst_not_early", o_vld, 0);
    tick();
    @(negedge CLK);
    chk("arst_ovld_after", o_vld, 1);
    chk("arst_outa_after", out_a, 4'h7);
    chk("arst_outb_after", out_b, 4'hA);
    tick();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
